// File: rtl/prism_sp_gem_cookie_pkg.sv
// Shared definitions for the GEM cookie producer and sink: cookie layout,
// field widths, FSM states and the event-to-cookie packing rule.
package prism_sp_gem_cookie_pkg;

  localparam int unsigned SEQ_W    = 6;
  localparam int unsigned ERR_W    = 1;
  localparam int unsigned IDX_W    = 11;
  localparam int unsigned LEN_W    = 14;
  localparam int unsigned EV_LEN_W = 16;

  localparam logic [LEN_W-1:0] LEN_MAX = 14'd16383;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [ERR_W-1:0] err;
    logic [IDX_W-1:0] index;
    logic [LEN_W-1:0] length;
  } cookie_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Oversized frames are clamped to LEN_MAX and flagged as errored.
  function automatic cookie_t pack_cookie(input logic [SEQ_W-1:0]    seq,
                                          input logic [IDX_W-1:0]    index,
                                          input logic [EV_LEN_W-1:0] ev_length,
                                          input logic                ev_error);
    cookie_t c;
    c.seq   = seq;
    c.index = index;
    if (ev_length > {2'b00, LEN_MAX}) begin
      c.length = LEN_MAX;
      c.err    = 1'b1;
    end else begin
      c.length = ev_length[LEN_W-1:0];
      c.err    = ev_error;
    end
    return c;
  endfunction

endpackage

// File: rtl/prism_sp_puzzle_hw_gem_cookie_gen.sv
// GEM cookie producer: packs completion events into 32-bit cookies with a
// rolling sequence number and writes them to the cookie FIFO via a holding register.
module prism_sp_puzzle_hw_gem_cookie_gen
  import prism_sp_gem_cookie_pkg::*;
#(
  parameter bit STALL_ON_FULL = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ev_valid,
  output logic        ev_ready,
  input  logic [10:0] ev_index,
  input  logic [15:0] ev_length,
  input  logic        ev_error,
  output logic        o_cookie_fifo_w_wr_en,
  output logic [31:0] o_cookie_fifo_w_din,
  input  logic        o_cookie_fifo_w_full,
  output logic [31:0] cookie_count,
  output logic [15:0] drop_count
);

  state_t      state_q, state_d;
  cookie_t     cookie_q, cookie_d;
  logic [5:0]  seq_q, seq_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] din_q, din_d;
  logic [31:0] cookie_count_q, cookie_count_d;
  logic [15:0] drop_count_q, drop_count_d;

  // Next-state, holding register and counter updates.
  always_comb begin
    state_d        = state_q;
    cookie_d       = cookie_q;
    seq_d          = seq_q;
    wr_en_d        = 1'b0;
    din_d          = din_q;
    cookie_count_d = cookie_count_q;
    drop_count_d   = drop_count_q;
    case (state_q)
      ST_IDLE: begin
        if (ev_valid) begin
          cookie_d = pack_cookie(seq_q, ev_index, ev_length, ev_error);
          seq_d    = seq_q + 6'd1;
          state_d  = ST_HOLD;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!o_cookie_fifo_w_full) begin
          wr_en_d        = 1'b1;
          din_d          = cookie_q;
          cookie_count_d = cookie_count_q + 32'd1;
          state_d        = ST_IDLE;
        end else if (STALL_ON_FULL) begin
          state_d        = ST_HOLD;
        end else begin
          // Saturate so a long overflow burst never wraps back to a small count.
          if (drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
          end else begin
            drop_count_d = drop_count_q;
          end
          state_d        = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset also kills any in-flight write pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cookie_q       <= '0;
      seq_q          <= 6'd0;
      wr_en_q        <= 1'b0;
      din_q          <= 32'd0;
      cookie_count_q <= 32'd0;
      drop_count_q   <= 16'd0;
    end else begin
      state_q        <= state_d;
      cookie_q       <= cookie_d;
      seq_q          <= seq_d;
      wr_en_q        <= wr_en_d;
      din_q          <= din_d;
      cookie_count_q <= cookie_count_d;
      drop_count_q   <= drop_count_d;
    end
  end

  assign ev_ready              = (state_q == ST_IDLE);
  assign o_cookie_fifo_w_wr_en = wr_en_q;
  assign o_cookie_fifo_w_din   = din_q;
  assign cookie_count          = cookie_count_q;
  assign drop_count            = drop_count_q;

endmodule
